// File: rtl/mc_control_pkg.sv
// mc_control_pkg: state encoding, opcodes and control-field codes for the multicycle controller
package mc_control_pkg;
   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX   = 4'd11,
      ORIEX   = 4'd12, ORIWB   = 4'd13, TRAP   = 4'd14
   } state_e;
   localparam int OP_LW    = 35;
   localparam int OP_SW    = 43;
   localparam int OP_RTYPE = 0;
   localparam int OP_BEQ   = 4;
   localparam int OP_ADDI  = 8;
   localparam int OP_J     = 2;
   localparam int OP_ORI   = 13;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;
endpackage

// File: rtl/mc_control_decode.sv
// mc_control_decode: Moore decode of the controller state into the datapath control word
module mc_control_decode
   import mc_control_pkg::*;
(
   input  logic [3:0] st,
   input  logic       active,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       branch,
   output logic       iord,
   output logic       alusrca,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       illegal
);
   // all strobes idle unless the state asserts them; everything is silenced while not active
   always_comb begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      branch   = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrcb  = SRCB_REG;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_ADD;
      illegal  = 1'b0;
      if (active)
         case (st)
            FETCH:   begin alusrcb = SRCB_FOUR; irwrite = mem_ready; pcwrite = mem_ready; end
            DECODE:  alusrcb = SRCB_BRANCH;
            MEMADR:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
            MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
            RTYPEEX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
            RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
            BEQEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = PCSRC_ALUOUT; branch = 1'b1; end
            ADDIEX:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
            ORIEX:   begin alusrca = 1'b1; alusrcb = SRCB_IMM; aluop = ALUOP_OR; end
            ADDIWB,
            ORIWB:   regwrite = 1'b1;
            JEX:     begin pcsrc = PCSRC_JUMP; pcwrite = 1'b1; end
            TRAP:    illegal = 1'b1;
            default: ;
         endcase
   end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset controller with memory wait, ORI and illegal-opcode trap
module mc_control_fsm
   import mc_control_pkg::*;
#(
   parameter int OPW         = 6,
   parameter int SW          = 6,
   parameter int MEM_WAIT_EN = 1,
   parameter int TRAP_EN     = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] op,
   input  logic           mem_ready,
   output logic [SW-1:0]  state,
   output logic           pcwrite,
   output logic           irwrite,
   output logic           memwrite,
   output logic           regwrite,
   output logic           branch,
   output logic           iord,
   output logic           alusrca,
   output logic           regdst,
   output logic           memtoreg,
   output logic [1:0]     alusrcb,
   output logic [1:0]     pcsrc,
   output logic [1:0]     aluop,
   output logic           illegal
);
   localparam logic [OPW-1:0] C_LW    = OPW'(OP_LW);
   localparam logic [OPW-1:0] C_SW    = OPW'(OP_SW);
   localparam logic [OPW-1:0] C_RTYPE = OPW'(OP_RTYPE);
   localparam logic [OPW-1:0] C_BEQ   = OPW'(OP_BEQ);
   localparam logic [OPW-1:0] C_ADDI  = OPW'(OP_ADDI);
   localparam logic [OPW-1:0] C_J     = OPW'(OP_J);
   localparam logic [OPW-1:0] C_ORI   = OPW'(OP_ORI);

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic           mr;

   assign mr    = (MEM_WAIT_EN == 0) || mem_ready;
   assign state = SW'(state_q);

   // next state; the opcode is captured in DECODE so MEMADR is immune to later op changes
   always_comb begin
      state_d = FETCH;
      op_d    = op_q;
      case (state_q)
         FETCH:   state_d = mr ? DECODE : FETCH;
         DECODE: begin
            op_d = op;
            if (op == C_LW || op == C_SW) state_d = MEMADR;
            else if (op == C_RTYPE)       state_d = RTYPEEX;
            else if (op == C_BEQ)         state_d = BEQEX;
            else if (op == C_ADDI)        state_d = ADDIEX;
            else if (op == C_J)           state_d = JEX;
            else if (op == C_ORI)         state_d = ORIEX;
            else                          state_d = (TRAP_EN != 0) ? TRAP : FETCH;
         end
         MEMADR:  state_d = (op_q == C_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = mr ? MEMWB : MEMRD;
         MEMWR:   state_d = mr ? FETCH : MEMWR;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         ORIEX:   state_d = ORIWB;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   // state and latched-opcode registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end

   mc_control_decode u_decode (
      .st        (state_q),
      .active    (!reset),
      .mem_ready (mr),
      .pcwrite   (pcwrite),
      .irwrite   (irwrite),
      .memwrite  (memwrite),
      .regwrite  (regwrite),
      .branch    (branch),
      .iord      (iord),
      .alusrca   (alusrca),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .alusrcb   (alusrcb),
      .pcsrc     (pcsrc),
      .aluop     (aluop),
      .illegal   (illegal)
   );
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control state machine for the MIPS-subset datapath; successor to the 6-bit `statelogic` controller. It sequences fetch/decode/execute/writeback from the opcode and drives every datapath control strobe. It adds three things over the previous generation:
- a memory wait handshake;
- ORI support;
- a sticky trap on illegal opcodes.

It sits between the instruction register (`op` source) and the datapath/memory interface.

## Interface
Parameters:
- `OPW`, 6, opcode width; opcode constants are zero-extended or truncated to OPW.
- `SW`, 6, width of the `state` output; must be ≥4. The encoding is zero-extended.
- `MEM_WAIT_EN`, 1. When 0, `mem_ready` is ignored and treated as 1.
- `TRAP_EN`, 1. When 0, an illegal opcode returns to FETCH instead of TRAP.

Ports:
- Clocking: one clock; reset is asynchronous and active-high. Ports are named `clk` and `reset`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `op` in OPW: opcode, sampled only in DECODE.
- `mem_ready` in 1: memory access completes this cycle.
- `state` out SW: current state encoding.
- `pcwrite`, `irwrite`, `memwrite`, `regwrite`, `branch`, `iord`, `alusrca`, `regdst`, `memtoreg` out 1 each: control strobes.
- `alusrcb`, `pcsrc`, `aluop` out 2 each: mux selects and ALU op class.
- `illegal` out 1: high while in TRAP.

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
- ORIEX=12, ORIWB=13, TRAP=14

Transitions:
- FETCH→DECODE when `mem_ready`; otherwise stay in FETCH.
- DECODE branches on `op`:
  - LW=35 or SW=43 → MEMADR
  - RTYPE=0 → RTYPEEX
  - BEQ=4 → BEQEX
  - ADDI=8 → ADDIEX
  - J=2 → JEX
  - ORI=13 → ORIEX
  - any other opcode → TRAP (or FETCH if TRAP_EN=0)
- MEMADR→MEMRD for LW, MEMWR for SW. The decision uses the opcode latched in DECODE; `op` may change after DECODE.
- MEMRD→MEMWB when `mem_ready`; otherwise stay.
- MEMWR→FETCH when `mem_ready`; otherwise stay.
- MEMWB, RTYPEWB, ADDIWB, ORIWB, BEQEX, JEX → FETCH.
- RTYPEEX→RTYPEWB; ADDIEX→ADDIWB; ORIEX→ORIWB.
- TRAP→TRAP until reset.
- Any unencoded state value → FETCH.

Outputs are Moore-decoded from `state`; every unlisted output is 0:
- FETCH: `alusrcb`=01, `irwrite`=`pcwrite`=`mem_ready`.
- DECODE: `alusrcb`=11.
- MEMADR: `alusrca`=1, `alusrcb`=10.
- MEMRD: `iord`=1.
- MEMWB: `memtoreg`=1, `regwrite`=1.
- MEMWR: `iord`=1, `memwrite`=1 (held for the whole wait).
- RTYPEEX: `alusrca`=1, `aluop`=10.
- RTYPEWB: `regdst`=1, `regwrite`=1.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
- ADDIEX: `alusrca`=1, `alusrcb`=10.
- ORIEX: `alusrca`=1, `alusrcb`=10, `aluop`=11.
- ADDIWB, ORIWB: `regwrite`=1.
- JEX: `pcsrc`=10, `pcwrite`=1.
- TRAP: `illegal`=1.

## Timing
- Reset: `state`=0 (FETCH) immediately, independent of `clk`. While `reset`=1, all strobes are 0, including `pcwrite`/`irwrite` regardless of `mem_ready`, and `illegal`=0.
- First FETCH begins on the first rising edge after reset deassertion.
- Zero-wait cycle counts, including FETCH:
  - LW: 5 cycles
  - SW: 4 cycles
  - R-type, ADDI, ORI: 4 cycles
  - BEQ, J: 3 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay stable during the wait.
- `op` must be valid in the DECODE cycle only; changes in any other state have no effect.
- Reset asserted mid-instruction or in TRAP returns to FETCH asynchronously; no partial strobes follow.

## Structure
- Package `mc_control_pkg`: state encoding localparams, opcode constants (LW, SW, RTYPE, BEQ, ADDI, J, ORI), and the `aluop`/`pcsrc`/`alusrcb` code constants.
- Sub-module `mc_control_decode`: purely combinational state→control-word decode, instantiated once. The top module holds the state register, the latched opcode and the next-state logic.

## Test plan
- Reset 20 ns, then `op`=35 with `mem_ready`=1 → state sequence 0,1,2,3,4,0; `regwrite`=1 and `memtoreg`=1 only in state 4.
- `op`=13 (ORI) → 0,1,12,13,0; `aluop`=11 in state 12; `regwrite`=1 in state 13.
- `op`=14 → 0,1,14; `illegal`=1 and the state holds at 14 for 10 cycles. Rerun with TRAP_EN=0 → 0,1,0.
- `op`=43 with `mem_ready` low for 3 cycles in MEMWR → state 5 for 4 cycles with `memwrite`=1 throughout, then 0.
- `mem_ready`=0 in FETCH for 2 cycles → `irwrite`=`pcwrite`=0, state stays 0; both pulse high for one cycle when `mem_ready` rises.
- `reset` asserted mid-cycle in state 7 (`op`=0) → `state`=0 and `regwrite`=0 before the next clock edge.
